ram_bist_ctrl: RTL and testbench
================================

# ram_bist_ctrl

Memory built-in self-test controller that drives one port of a `ram_dual` instance (128 x 8, synchronous write, registered read) as the initiator. On `start` it runs a four-element march test and reports `pass`, plus the first failing address and read data. It sits beside the dual-port RAM and owns that port during test; the other port is unaffected.

## Interface
- `ADDR_W`, 7, RAM address width; depth = 2**ADDR_W
- `DATA_W`, 8, RAM data width
- `PATTERN`, 8'h55, background pattern P; its complement ~P is the second pattern
- `clk` in 1, single clock, rising edge
- `rst` in 1, asynchronous, active-high reset
- `start` in 1, level-sampled request to begin a test
- `busy` out 1, high while a test runs
- `done` out 1, high from test end until the next accepted start
- `pass` out 1, valid while `done`; 1 = no mismatch
- `fail_addr` out ADDR_W, address of the first mismatch
- `fail_data` out DATA_W, `ram_q` value at the first mismatch
- `ram_a` out ADDR_W, RAM address
- `ram_d` out DATA_W, RAM write data
- `ram_we` out 1, RAM write enable
- `ram_q` in DATA_W, RAM read data; valid one cycle after its address is presented with `ram_we`=0

## Operation
- States: IDLE, W_UP, RD_UP, WR_UP, RD_DN, WR_DN, RD_FIN, CK_FIN, DONE.
- IDLE/DONE: `start`=1 clears `done`/`pass`/`fail_*`, sets addr=0, goes to W_UP. `start` is ignored in every other state.
- W_UP: write P to addr, ascending. At addr = max, go to RD_UP; addr wraps to 0.
- RD_UP (`ram_we`=0) -> WR_UP: compare `ram_q` with P, write ~P to the same addr. Ascending. After max, go to RD_DN; addr holds at max.
- RD_DN -> WR_DN: compare with ~P, write P. Descending. After addr 0, go to RD_FIN; addr holds at 0.
- RD_FIN -> CK_FIN: compare with P, no write. Ascending. After max, go to DONE with `pass`=1.
- Mismatch in any compare state:
  - Capture `fail_addr`=addr and `fail_data`=`ram_q`.
  - Next state is DONE with `pass`=0.
  - The write in that WR_* cycle still occurs.
- `ram_a`, `ram_d`, `ram_we` are decoded only from the state and address registers. There is no combinational path from `start` or `ram_q` to any output.
- In IDLE/DONE the RAM outputs are `ram_we`=0, `ram_a`=0, `ram_d`=0.
- Reset, asynchronous, at any time including mid-test:
  - State = IDLE, addr = 0.
  - All outputs 0: `busy`, `done`, `pass`, `fail_addr`, `fail_data`, `ram_a`, `ram_d`, `ram_we`.
  - RAM contents are undefined afterwards.

## Timing
- Cycle 0 is the edge where `start` is sampled. Cycle numbering below is for depth 128.
- W_UP: cycles 1..128.
- RD_UP/WR_UP for addr k: cycles 129+2k and 130+2k.
- RD_DN/WR_DN for addr k: cycles 385+2(127-k) and 386+2(127-k).
- RD_FIN/CK_FIN for addr k: cycles 641+2k and 642+2k.
- Clean run: `done`=1 and `busy`=0 from cycle 897, i.e. 7*2**ADDR_W + 1.
- Failure: `done` rises the cycle after the failing compare cycle.
- `busy` is high in every state except IDLE and DONE.

## Structure
- Shared package `ram_bist_pkg`: state enum, default `PATTERN`, address/data width constants.
- Sub-module `ram_bist_addr_cnt`: up/down counter with hold and terminal-count flags (`at_max`, `at_zero`).
- FSM and compare logic stay in the top module.

## Test plan
- Reset: assert `rst` mid-clock. All outputs read 0 immediately, without waiting for a clock edge.
- Fault-free `ram_dual` model, one-cycle `start` pulse:
  - `busy` is high on cycles 1..896.
  - `done`=1 and `pass`=1 on cycle 897.
  - A bench monitor sees 128 writes of 8'h55, then alternating read/write 8'hAA ascending, then 8'h55 descending.
- Stuck-at-0 on bit 0 at addr 7'h2A:
  - `done` at cycle 215.
  - `pass`=0, `fail_addr`=7'h2A, `fail_data`=8'h54.
- Stuck-at-0 on bit 1 at addr 7'h7F (fault is only visible under ~P):
  - `done` at cycle 387.
  - `pass`=0, `fail_addr`=7'h7F, `fail_data`=8'hA8.
- `rst` pulse at cycle 300, then `start`: full clean run, with `done` 897 cycles after the new start edge.
- `start` held high throughout:
  - Ignored while `busy`.
  - Re-accepted in DONE: `done` is high for exactly one cycle, then a new run begins.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM march-test controller: FSM states, counter
// opcodes and default geometry / background pattern.
package ram_bist_pkg;

    localparam int          ADDR_W_DEF  = 7;
    localparam int          DATA_W_DEF  = 8;
    localparam logic [7:0]  PATTERN_DEF = 8'h55;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_W_UP   = 4'd1,
        ST_RD_UP  = 4'd2,
        ST_WR_UP  = 4'd3,
        ST_RD_DN  = 4'd4,
        ST_WR_DN  = 4'd5,
        ST_RD_FIN = 4'd6,
        ST_CK_FIN = 4'd7,
        ST_DONE   = 4'd8
    } bist_state_e;

    localparam logic [1:0] CNT_HOLD = 2'd0;
    localparam logic [1:0] CNT_INC  = 2'd1;
    localparam logic [1:0] CNT_DEC  = 2'd2;
    localparam logic [1:0] CNT_CLR  = 2'd3;

endpackage

// File: rtl/ram_bist_addr_cnt.sv
// March address counter: up/down/hold/clear with terminal-count flags.
module ram_bist_addr_cnt
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        op,
    output logic [ADDR_W-1:0] count,
    output logic              at_max,
    output logic              at_zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case (op)
                CNT_INC: count <= count + 1'b1;
                CNT_DEC: count <= count - 1'b1;
                CNT_CLR: count <= '0;
                default: count <= count;
            endcase
        end
    end

    assign at_max  = &count;
    assign at_zero = ~|count;

endmodule

// File: rtl/ram_bist.sv
// March BIST controller (W0 up; R0/W1 up; R1/W0 down; R0 final) driving one
// port of a registered-read RAM and reporting pass plus first failing address/data.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter int                DATA_W  = DATA_W_DEF,
    parameter logic [DATA_W-1:0] PATTERN = PATTERN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    output logic [3:0]        dbg_state
);

    // Handshake: start is a level request, accepted only on a rising edge where
    // the FSM sits in IDLE or DONE; busy rises the following cycle as the
    // acknowledge and start is ignored until done is reported again.

    bist_state_e       state, state_nx;
    logic [1:0]        cnt_op;
    logic [ADDR_W-1:0] addr;
    logic              at_max, at_zero;
    logic              clear, fail_set, pass_set;
    logic [DATA_W-1:0] exp_rd;
    logic              mismatch;

    ram_bist_addr_cnt #(.ADDR_W(ADDR_W)) u_addr_cnt (
        .clk     (clk),
        .rst     (rst),
        .op      (cnt_op),
        .count   (addr),
        .at_max  (at_max),
        .at_zero (at_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Read data is compared in the cycle after the read address was presented.
    always_comb begin
        exp_rd = PATTERN;
        if (state == ST_WR_DN) exp_rd = ~PATTERN;
    end

    assign mismatch = (ram_q != exp_rd);

    always_comb begin
        state_nx = state;
        cnt_op   = CNT_HOLD;
        clear    = 1'b0;
        fail_set = 1'b0;
        pass_set = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nx = ST_W_UP;
                    cnt_op   = CNT_CLR;
                    clear    = 1'b1;
                end
            end
            ST_W_UP: begin
                cnt_op = CNT_INC;
                if (at_max) state_nx = ST_RD_UP;
            end
            ST_RD_UP: state_nx = ST_WR_UP;
            ST_WR_UP: begin
                if (mismatch) begin
                    fail_set = 1'b1;
                    state_nx = ST_DONE;
                end else if (at_max) begin
                    state_nx = ST_RD_DN;
                end else begin
                    cnt_op   = CNT_INC;
                    state_nx = ST_RD_UP;
                end
            end
            ST_RD_DN: state_nx = ST_WR_DN;
            ST_WR_DN: begin
                if (mismatch) begin
                    fail_set = 1'b1;
                    state_nx = ST_DONE;
                end else if (at_zero) begin
                    state_nx = ST_RD_FIN;
                end else begin
                    cnt_op   = CNT_DEC;
                    state_nx = ST_RD_DN;
                end
            end
            ST_RD_FIN: state_nx = ST_CK_FIN;
            ST_CK_FIN: begin
                if (mismatch) begin
                    fail_set = 1'b1;
                    state_nx = ST_DONE;
                end else if (at_max) begin
                    pass_set = 1'b1;
                    state_nx = ST_DONE;
                end else begin
                    cnt_op   = CNT_INC;
                    state_nx = ST_RD_FIN;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (clear) begin
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (fail_set) begin
            pass      <= 1'b0;
            fail_addr <= addr;
            fail_data <= ram_q;
        end else if (pass_set) begin
            pass      <= 1'b1;
        end
    end

    // RAM port is a pure decode of state and address; the write of a failing
    // WR_* cycle still happens because the decode ignores the compare result.
    always_comb begin
        ram_we = 1'b0;
        ram_d  = '0;
        case (state)
            ST_W_UP:  begin ram_we = 1'b1; ram_d = PATTERN;  end
            ST_WR_UP: begin ram_we = 1'b1; ram_d = ~PATTERN; end
            ST_WR_DN: begin ram_we = 1'b1; ram_d = PATTERN;  end
            default:  begin ram_we = 1'b0; ram_d = '0;       end
        endcase
    end

    assign busy      = (state != ST_IDLE) && (state != ST_DONE);
    assign done      = (state == ST_DONE);
    assign ram_a     = busy ? addr : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl: behavioural RAM with an optional
// stuck-at cell and a march-test reference model computed from the test rules.
module tb_ram_bist_ctrl;

    localparam logic [7:0] P  = 8'h55;
    localparam logic [7:0] NP = 8'hAA;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, pass, ram_we;
    logic [6:0] fail_addr, ram_a;
    logic [7:0] fail_data, ram_d;
    logic [7:0] ram_q = 8'h00;
    logic [3:0] dbg_state;

    int checks = 0;
    int errors = 0;

    // fault injection for the RAM model
    bit         fault_en  = 1'b0;
    int         fault_adr = 0;
    int         fault_bit = 0;
    logic       fault_val = 1'b0;

    logic [7:0]  mem [128];
    bit          mon_en = 1'b0;
    logic [14:0] obs_q[$];
    logic [14:0] exp_q[$];

    always #5 clk = ~clk;

    ram_bist_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .ram_a     (ram_a),
        .ram_d     (ram_d),
        .ram_we    (ram_we),
        .ram_q     (ram_q),
        .dbg_state (dbg_state)
    );

    function automatic logic [7:0] flt(input bit en, input int fa, input int fb,
                                       input logic fv, input int a, input logic [7:0] d);
        logic [7:0] r;
        r = d;
        if (en && a == fa) r[fb] = fv;
        return r;
    endfunction

    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= flt(fault_en, fault_adr, fault_bit, fault_val, int'(ram_a), ram_d);
        else        ram_q <= mem[ram_a];
        if (mon_en && ram_we) obs_q.push_back({ram_a, ram_d});
    end

    // Reference march: returns cycle done rises, pass and the first failure.
    task automatic model(input bit en, input int fa, input int fb, input logic fv,
                         output int dc, output logic p,
                         output logic [6:0] xa, output logic [7:0] xd);
        logic [7:0] m [128];
        dc = 897; p = 1'b1; xa = '0; xd = '0;
        for (int k = 0; k < 128; k++) m[k] = flt(en, fa, fb, fv, k, P);
        for (int k = 0; k < 128; k++) begin
            if (m[k] != P) begin dc = 131 + 2*k; p = 0; xa = 7'(k); xd = m[k]; return; end
            m[k] = flt(en, fa, fb, fv, k, NP);
        end
        for (int k = 127; k >= 0; k--) begin
            if (m[k] != NP) begin dc = 387 + 2*(127-k); p = 0; xa = 7'(k); xd = m[k]; return; end
            m[k] = flt(en, fa, fb, fv, k, P);
        end
        for (int k = 0; k < 128; k++) begin
            if (m[k] != P) begin dc = 643 + 2*k; p = 0; xa = 7'(k); xd = m[k]; return; end
        end
    endtask

    function automatic logic [6:0] exp_addr(input int c);
        if (c <= 128) return 7'(c - 1);
        if (c <= 384) return 7'((c - 129) / 2);
        if (c <= 640) return 7'(127 - (c - 385) / 2);
        return 7'((c - 641) / 2);
    endfunction

    function automatic logic exp_we(input int c);
        if (c <= 128) return 1'b1;
        if (c <= 640) return (c % 2) == 0;
        return 1'b0;
    endfunction

    // Pulses (or holds) start and checks every cycle up to and including done.
    task automatic run_and_check(input string name, input int dc, input logic ep,
                                 input logic [6:0] ea, input logic [7:0] ed, input bit hold);
        logic       xb, xw;
        logic [6:0] xadr;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= dc; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) start = 1'b0;
            xb   = (c < dc);
            xw   = xb ? exp_we(c) : 1'b0;
            xadr = xb ? exp_addr(c) : 7'd0;
            checks++;
            if (busy !== xb || done !== !xb || ram_we !== xw || ram_a !== xadr) begin
                errors++;
                $display("FAIL %s cycle %0d: busy/done/we/a got %b/%b/%b/%h want %b/%b/%b/%h",
                         name, c, busy, done, ram_we, ram_a, xb, !xb, xw, xadr);
            end
        end
        checks++;
        if (pass !== ep || fail_addr !== ea || fail_data !== ed) begin
            errors++;
            $display("FAIL %s result: pass/addr/data got %b/%h/%h want %b/%h/%h",
                     name, pass, fail_addr, fail_data, ep, ea, ed);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({busy, done, pass, fail_addr, fail_data, ram_a, ram_d, ram_we, dbg_state} !== '0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b pass=%b fa=%h fd=%h a=%h d=%h we=%b st=%h want all 0",
                     name, busy, done, pass, fail_addr, fail_data, ram_a, ram_d, ram_we, dbg_state);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic set_fault(input bit en, input int fa, input int fb, input logic fv);
        fault_en = en; fault_adr = fa; fault_bit = fb; fault_val = fv;
    endtask

    task automatic test_reset();
        apply_reset();
        check_all_zero("reset_idle");
    endtask

    task automatic test_clean();
        int dc; logic p; logic [6:0] xa; logic [7:0] xd;
        set_fault(0, 0, 0, 0);
        model(0, 0, 0, 0, dc, p, xa, xd);
        exp_q.delete(); obs_q.delete();
        for (int k = 0; k < 128; k++)   exp_q.push_back({7'(k), P});
        for (int k = 0; k < 128; k++)   exp_q.push_back({7'(k), NP});
        for (int k = 127; k >= 0; k--)  exp_q.push_back({7'(k), P});
        mon_en = 1'b1;
        run_and_check("clean", dc, p, xa, xd, 1'b0);
        mon_en = 1'b0;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL clean_write_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL clean_write[%0d]: got a=%h d=%h want a=%h d=%h",
                         i, obs_q[i][14:8], obs_q[i][7:0], exp_q[i][14:8], exp_q[i][7:0]);
            end
        end
    endtask

    task automatic test_fault_bit0();
        set_fault(1, 'h2A, 0, 1'b0);
        run_and_check("stuck0_bit0_2a", 215, 1'b0, 7'h2A, 8'h54, 1'b0);
    endtask

    task automatic test_fault_bit1_top();
        set_fault(1, 'h7F, 1, 1'b0);
        run_and_check("stuck0_bit1_7f", 387, 1'b0, 7'h7F, 8'hA8, 1'b0);
    endtask

    task automatic test_async_reset();
        // in DONE after a failure: fail_* are nonzero, reset must clear at once
        set_fault(1, 'h2A, 0, 1'b0);
        run_and_check("pre_reset_fail", 215, 1'b0, 7'h2A, 8'h54, 1'b0);
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset_done");
        @(negedge clk) rst = 1'b0;
        // mid-run, with RAM outputs active
        set_fault(0, 0, 0, 0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset_run");
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_random_faults();
        int dc, fa, fb; logic p, fv; logic [6:0] xa; logic [7:0] xd;
        for (int i = 0; i < 4; i++) begin
            fa = int'($urandom_range(0, 127));
            fb = int'($urandom_range(0, 7));
            fv = 1'($urandom_range(0, 1));
            set_fault(1, fa, fb, fv);
            model(1, fa, fb, fv, dc, p, xa, xd);
            run_and_check($sformatf("rand_fault_%0d", i), dc, p, xa, xd, 1'b0);
        end
    endtask

    task automatic test_reset_mid_run();
        set_fault(0, 0, 0, 0);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (299) @(negedge clk);
        rst = 1'b1;
        #1 check_all_zero("reset_cycle300");
        @(negedge clk) rst = 1'b0;
        run_and_check("after_reset_run", 897, 1'b1, 7'h00, 8'h00, 1'b0);
    endtask

    task automatic test_start_held();
        set_fault(0, 0, 0, 0);
        run_and_check("start_held", 897, 1'b1, 7'h00, 8'h00, 1'b1);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b1 || ram_we !== 1'b1 || ram_a !== 7'(c - 1)) begin
                errors++;
                $display("FAIL restart_cycle%0d: done/busy/we/a got %b/%b/%b/%h want 0/1/1/%h",
                         c, done, busy, ram_we, ram_a, 7'(c - 1));
            end
        end
        start = 1'b0;
        apply_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean();
        test_fault_bit0();
        test_fault_bit1_top();
        test_async_reset();
        test_random_faults();
        test_reset_mid_run();
        test_start_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
